// File: rtl/apb_pkg.sv
// Shared types and defaults for the APB3 master bridge and its address decoder.
package apb_pkg;

    localparam logic [31:0] BASE_ADDR_DFLT   = 32'h1000_0000;
    localparam int unsigned REGION_BITS_DFLT = 12;
    localparam int unsigned NUM_SLAVES       = 4;
    localparam int unsigned DATA_W           = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    typedef logic [1:0] slot_t;

endpackage

// File: rtl/apb_addr_decoder.sv
// Maps the latched APB address to one of four slave windows and muxes that slave's response.
// Optional APB_MASTER_SLVERR_EN adds the PSLVERR inputs and a muxed sel_err output.
module apb_addr_decoder
    import apb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DFLT,
    parameter int unsigned REGION_BITS = REGION_BITS_DFLT
) (
    input  logic [31:REGION_BITS] addr_hi,
    input  logic                  active,
    input  logic                  PREADY0,
    input  logic                  PREADY1,
    input  logic                  PREADY2,
    input  logic                  PREADY3,
    input  logic [DATA_W-1:0]     PRDATA0,
    input  logic [DATA_W-1:0]     PRDATA1,
    input  logic [DATA_W-1:0]     PRDATA2,
    input  logic [DATA_W-1:0]     PRDATA3,
`ifdef APB_MASTER_SLVERR_EN
    input  logic                  PSLVERR0,
    input  logic                  PSLVERR1,
    input  logic                  PSLVERR2,
    input  logic                  PSLVERR3,
    output logic                  sel_err,
`endif
    output logic                  PSEL0,
    output logic                  PSEL1,
    output logic                  PSEL2,
    output logic                  PSEL3,
    output logic                  hit,
    output logic                  sel_ready,
    output logic [DATA_W-1:0]     sel_rdata
);

    slot_t slot;

    assign slot = slot_t'(addr_hi[REGION_BITS+1:REGION_BITS]);
    assign hit  = (addr_hi[31:REGION_BITS+2] == BASE_ADDR[31:REGION_BITS+2]);

    // An unmapped address reports ready at once with zero data so the master never stalls.
    always_comb begin
        PSEL0     = 1'b0;
        PSEL1     = 1'b0;
        PSEL2     = 1'b0;
        PSEL3     = 1'b0;
        sel_ready = 1'b1;
        sel_rdata = '0;
`ifdef APB_MASTER_SLVERR_EN
        sel_err   = 1'b0;
`endif
        if (hit) begin
            unique case (slot)
                2'd0: begin
                    PSEL0     = active;
                    sel_ready = PREADY0;
                    sel_rdata = PRDATA0;
`ifdef APB_MASTER_SLVERR_EN
                    sel_err   = PSLVERR0;
`endif
                end
                2'd1: begin
                    PSEL1     = active;
                    sel_ready = PREADY1;
                    sel_rdata = PRDATA1;
`ifdef APB_MASTER_SLVERR_EN
                    sel_err   = PSLVERR1;
`endif
                end
                2'd2: begin
                    PSEL2     = active;
                    sel_ready = PREADY2;
                    sel_rdata = PRDATA2;
`ifdef APB_MASTER_SLVERR_EN
                    sel_err   = PSLVERR2;
`endif
                end
                default: begin
                    PSEL3     = active;
                    sel_ready = PREADY3;
                    sel_rdata = PRDATA3;
`ifdef APB_MASTER_SLVERR_EN
                    sel_err   = PSLVERR3;
`endif
                end
            endcase
        end
    end

endmodule

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB3 master: one-cycle request -> SETUP/ACCESS transfer on one of four slaves.
// Optional APB_MASTER_SLVERR_EN adds PSLVERR0..3 inputs and an err output.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DFLT,
    parameter int unsigned REGION_BITS = REGION_BITS_DFLT
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              transfer,
    input  logic              write,
    input  logic [31:0]       addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] PRDATA0,
    input  logic [DATA_W-1:0] PRDATA1,
    input  logic [DATA_W-1:0] PRDATA2,
    input  logic [DATA_W-1:0] PRDATA3,
    input  logic              PREADY0,
    input  logic              PREADY1,
    input  logic              PREADY2,
    input  logic              PREADY3,
`ifdef APB_MASTER_SLVERR_EN
    input  logic              PSLVERR0,
    input  logic              PSLVERR1,
    input  logic              PSLVERR2,
    input  logic              PSLVERR3,
    output logic              err,
`endif
    output logic              ready,
    output logic [DATA_W-1:0] rdata,
    output logic [31:0]       PADDR,
    output logic              PWRITE,
    output logic              PENABLE,
    output logic [DATA_W-1:0] PWDATA,
    output logic              PSEL0,
    output logic              PSEL1,
    output logic              PSEL2,
    output logic              PSEL3
);

    apb_state_t        state, state_nxt;
    logic              hit;
    logic              sel_ready;
    logic [DATA_W-1:0] sel_rdata;
`ifdef APB_MASTER_SLVERR_EN
    logic              sel_err;
`endif

    // State register
    always_ff @(posedge PCLK) begin
        if (PRESET) state <= IDLE;
        else        state <= state_nxt;
    end

    // Request capture; held through IDLE so the bus shows the last transfer
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            PADDR  <= '0;
            PWRITE <= 1'b0;
            PWDATA <= '0;
        end else if (state == IDLE && transfer) begin
            PADDR  <= addr;
            PWRITE <= write;
            PWDATA <= wdata;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (transfer) state_nxt = SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (sel_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Completion outputs; a reset arriving in ACCESS suppresses ready for the aborted transfer
    always_comb begin
        PENABLE = (state == ACCESS);
        ready   = (state == ACCESS) && sel_ready && !PRESET;
        rdata   = '0;
        if (ready && !PWRITE && hit) rdata = sel_rdata;
`ifdef APB_MASTER_SLVERR_EN
        err     = ready && (!hit || sel_err);
`endif
    end

    apb_addr_decoder #(
        .BASE_ADDR   (BASE_ADDR),
        .REGION_BITS (REGION_BITS)
    ) u_dec (
        .addr_hi   (PADDR[31:REGION_BITS]),
        .active    (state != IDLE),
        .PREADY0   (PREADY0),
        .PREADY1   (PREADY1),
        .PREADY2   (PREADY2),
        .PREADY3   (PREADY3),
        .PRDATA0   (PRDATA0),
        .PRDATA1   (PRDATA1),
        .PRDATA2   (PRDATA2),
        .PRDATA3   (PRDATA3),
`ifdef APB_MASTER_SLVERR_EN
        .PSLVERR0  (PSLVERR0),
        .PSLVERR1  (PSLVERR1),
        .PSLVERR2  (PSLVERR2),
        .PSLVERR3  (PSLVERR3),
        .sel_err   (sel_err),
`endif
        .PSEL0     (PSEL0),
        .PSEL1     (PSEL1),
        .PSEL2     (PSEL2),
        .PSEL3     (PSEL3),
        .hit       (hit),
        .sel_ready (sel_ready),
        .sel_rdata (sel_rdata)
    );

endmodule

// File: tb/tb_apb_master_bridge.sv
// Randomized bench for apb_master_bridge: the bench plays all four APB slaves and predicts
// every bus cycle from an address-range / memory model. Honours APB_MASTER_SLVERR_EN.
module tb_apb_master_bridge;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        transfer, write;
    logic [31:0] addr, wdata;
    logic        ready;
    logic [31:0] rdata, PADDR, PWDATA;
    logic        PWRITE, PENABLE;
    logic        PSEL0, PSEL1, PSEL2, PSEL3;
    logic [31:0] prd  [4];
    logic        prdy [4];
    logic        pse  [4];
    logic [3:0]  psel_v;
`ifdef APB_MASTER_SLVERR_EN
    logic        err;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] mem [logic [31:0]];

    always #5 PCLK = ~PCLK;

    assign psel_v = {PSEL3, PSEL2, PSEL1, PSEL0};

    apb_master_bridge dut (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .transfer (transfer),
        .write    (write),
        .addr     (addr),
        .wdata    (wdata),
        .PRDATA0  (prd[0]),
        .PRDATA1  (prd[1]),
        .PRDATA2  (prd[2]),
        .PRDATA3  (prd[3]),
        .PREADY0  (prdy[0]),
        .PREADY1  (prdy[1]),
        .PREADY2  (prdy[2]),
        .PREADY3  (prdy[3]),
`ifdef APB_MASTER_SLVERR_EN
        .PSLVERR0 (pse[0]),
        .PSLVERR1 (pse[1]),
        .PSLVERR2 (pse[2]),
        .PSLVERR3 (pse[3]),
        .err      (err),
`endif
        .ready    (ready),
        .rdata    (rdata),
        .PADDR    (PADDR),
        .PWRITE   (PWRITE),
        .PENABLE  (PENABLE),
        .PWDATA   (PWDATA),
        .PSEL0    (PSEL0),
        .PSEL1    (PSEL1),
        .PSEL2    (PSEL2),
        .PSEL3    (PSEL3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Four 4 KB windows starting at 0x1000_0000; anything else is unmapped (-1)
    function automatic int exp_slot(input logic [31:0] a);
        longint off;
        off = longint'(a) - longint'(32'h1000_0000);
        if (off >= 0 && off < 64'd16384) return int'(off / 4096);
        return -1;
    endfunction

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 32'h0;
    endfunction

    task automatic rand_slaves();
        for (int i = 0; i < 4; i++) begin
            prdy[i] = 1'($urandom);
            prd[i]  = $urandom;
            pse[i]  = 1'($urandom);
        end
    endtask

    task automatic junk_req();
        write = 1'($urandom);
        addr  = $urandom;
        wdata = $urandom;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_paddr"},   PADDR, 32'h0);
        chk({tag, "_pwdata"},  PWDATA, 32'h0);
        chk({tag, "_pwrite"},  32'(PWRITE), 32'h0);
        chk({tag, "_penable"}, 32'(PENABLE), 32'h0);
        chk({tag, "_psel"},    32'(psel_v), 32'h0);
        chk({tag, "_ready"},   32'(ready), 32'h0);
        chk({tag, "_rdata"},   rdata, 32'h0);
`ifdef APB_MASTER_SLVERR_EN
        chk({tag, "_err"},     32'(err), 32'h0);
`endif
    endtask

    // One request: drives the request, acts as the selected slave with 'waits' wait states,
    // throws ignored junk requests at the bridge while busy, and checks every bus cycle.
    task automatic xfer(input logic wr, input logic [31:0] a, input logic [31:0] d, input int waits);
        int          s;
        logic [3:0]  ep;
        logic        done;
        logic        se;
        logic [31:0] erd;
        s  = exp_slot(a);
        ep = (s < 0) ? 4'b0 : 4'(1 << s);

        @(negedge PCLK);
        transfer = 1'b1; write = wr; addr = a; wdata = d;
        rand_slaves();

        @(negedge PCLK);
        transfer = 1'($urandom);
        junk_req();
        rand_slaves();
        #1;
        chk("setup_psel",    32'(psel_v), 32'(ep));
        chk("setup_penable", 32'(PENABLE), 32'h0);
        chk("setup_paddr",   PADDR, a);
        chk("setup_pwrite",  32'(PWRITE), 32'(wr));
        chk("setup_pwdata",  PWDATA, d);
        chk("setup_ready",   32'(ready), 32'h0);

        for (int k = 0; k <= waits; k++) begin
            @(negedge PCLK);
            done     = (s < 0) || (k == waits);
            transfer = done ? 1'b0 : 1'($urandom);
            junk_req();
            rand_slaves();
            se = 1'b0;
            if (s >= 0) begin
                prdy[s] = (k == waits);
                prd[s]  = model_rd(a);
                se      = pse[s];
            end
            #1;
            erd = (done && !wr) ? model_rd(a) : 32'h0;
            if (s < 0) erd = 32'h0;
            chk("acc_psel",    32'(psel_v), 32'(ep));
            chk("acc_penable", 32'(PENABLE), 32'h1);
            chk("acc_paddr",   PADDR, a);
            chk("acc_pwrite",  32'(PWRITE), 32'(wr));
            chk("acc_pwdata",  PWDATA, d);
            chk("acc_ready",   32'(ready), 32'(done));
            chk("acc_rdata",   rdata, erd);
`ifdef APB_MASTER_SLVERR_EN
            chk("acc_err",     32'(err), 32'(done && (s < 0 || se)));
`endif
            if (done) break;
        end
        if (wr && s >= 0) mem[a] = d;

        @(negedge PCLK);
        transfer = 1'b0;
        rand_slaves();
        #1;
        chk("idle_psel",    32'(psel_v), 32'h0);
        chk("idle_penable", 32'(PENABLE), 32'h0);
        chk("idle_ready",   32'(ready), 32'h0);
        chk("idle_rdata",   rdata, 32'h0);
        chk("idle_paddr",   PADDR, a);
        chk("idle_pwrite",  32'(PWRITE), 32'(wr));
    endtask

    initial begin
        logic [31:0] ra;
        PRESET = 1'b1; transfer = 1'b0; write = 1'b0; addr = '0; wdata = '0;
        for (int i = 0; i < 4; i++) begin prdy[i] = 1'b0; prd[i] = '0; pse[i] = 1'b0; end
        repeat (2) @(posedge PCLK);
        @(negedge PCLK); #1;
        chk_all_zero("reset");
        PRESET = 1'b0;

        // RAM writes and read-back
        xfer(1'b1, 32'h1000_0000, 32'd1, 0);
        xfer(1'b1, 32'h1000_0004, 32'd2, 1);
        xfer(1'b1, 32'h1000_0008, 32'd3, 0);
        xfer(1'b0, 32'h1000_0000, 32'h0, 0);
        xfer(1'b0, 32'h1000_0004, 32'h0, 2);
        xfer(1'b0, 32'h1000_0008, 32'h0, 0);
        // Peripheral windows
        xfer(1'b1, 32'h1000_1000, 32'd11, 0);
        xfer(1'b1, 32'h1000_2000, 32'd12, 0);
        xfer(1'b1, 32'h1000_3000, 32'd100, 0);
        xfer(1'b0, 32'h1000_3000, 32'h0, 0);
        // Long wait state: PENABLE held four cycles
        xfer(1'b0, 32'h1000_1000, 32'h0, 3);
        // Window edges and unmapped addresses
        xfer(1'b1, 32'h1000_3FFC, 32'hCAFE_F00D, 1);
        xfer(1'b0, 32'h1000_3FFC, 32'h0, 0);
        xfer(1'b0, 32'h2000_0000, 32'h0, 0);
        xfer(1'b0, 32'h1000_4000, 32'h0, 0);
        xfer(1'b1, 32'h0FFF_FFFC, 32'h1234_5678, 0);

        // Reset while a read waits in ACCESS, with the slave finishing in the reset cycle
        @(negedge PCLK);
        transfer = 1'b1; write = 1'b0; addr = 32'h1000_2000; wdata = 32'h55;
        for (int i = 0; i < 4; i++) prdy[i] = 1'b0;
        @(negedge PCLK); transfer = 1'b0;
        @(negedge PCLK); #1;
        chk("abort_penable", 32'(PENABLE), 32'h1);
        chk("abort_ready_wait", 32'(ready), 32'h0);
        @(negedge PCLK);
        PRESET = 1'b1; prdy[2] = 1'b1; prd[2] = 32'hDEAD_BEEF;
        #1;
        chk("abort_ready_rst", 32'(ready), 32'h0);
        @(negedge PCLK); #1;
        chk_all_zero("abort");
        PRESET = 1'b0;
        xfer(1'b0, 32'h1000_2000, 32'h0, 1);

        // Randomized traffic over mapped words and unmapped holes
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 4))
                0:       ra = $urandom;
                1:       ra = 32'h1000_4000 + 32'(4 * $urandom_range(0, 3));
                default: ra = 32'h1000_0000 + 32'($urandom_range(0, 3) * 4096)
                              + 32'(4 * $urandom_range(0, 3));
            endcase
            xfer(1'($urandom), ra, $urandom, int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
